muldiv_hilo: RTL and testbench
==============================

MULDIV_HILO -- requirements
Module: muldiv_hilo

Interface
REQ-001 SHALL have parameter: MUL_STAGES, 2, multiply latency in cycles after acceptance (legal 1..4).
REQ-002 SHALL have port: clk  in  1  sole clock; all state on rising edge.
REQ-003 SHALL have port: reset  in  1  reset is synchronous and active-high.
REQ-004 SHALL have port: ex_valid  in  1  EX-stage instruction valid.
REQ-005 SHALL have port: func  in  6  EX function code; acts on MULT, MULTU, DIV, DIVU, MTHI, MTLO only.
REQ-006 SHALL have port: A  in  32  rs operand (dividend / multiplicand).
REQ-007 SHALL have port: B  in  32  rt operand (divisor / multiplier).
REQ-008 SHALL have port: alu_res  in  32  EX ALU result; carries rs for MTHI/MTLO.
REQ-009 SHALL have port: flush  in  1  exception flush, cancels EX-stage work.
REQ-010 SHALL have port: busy  out  1  stall request to pipeline (combinational).
REQ-011 SHALL have port: hi  out  32  architectural HI register (registered).
REQ-012 SHALL have port: lo  out  32  architectural LO register (registered).

Function
REQ-013 SHALL implement states IDLE, MUL, DIV; start = ex_valid & IDLE & !flush & func in {MULT,MULTU,DIV,DIVU}.
REQ-014 SHALL capture A, B, signedness on start (cycle 0); IDLE->MUL or IDLE->DIV.
REQ-015 SHALL hold MUL for MUL_STAGES cycles (cycles 1..M); busy=1 in cycles 0..M-1, busy=0 in cycle M; HI/LO written at end of cycle M; MUL->IDLE.
REQ-016 SHALL compute MULT as signed 32x32->64, MULTU unsigned; HI=product[63:32], LO=product[31:0].
REQ-017 SHALL divide by 32-iteration restoring algorithm on magnitudes, one quotient bit per cycle in cycles 1..32; busy=1 cycles 0..31, 0 in cycle 32; HI/LO written end of cycle 32; DIV->IDLE.
REQ-018 SHALL set LO=quotient, HI=remainder; DIV: quotient negated iff operand signs differ, remainder takes dividend sign; DIVU unsigned.
REQ-019 SHALL, on divisor zero, raise no exception and return LO=0xFFFFFFFF (DIVU) / per-sign-fixed magnitude result (DIV), HI=dividend; latency unchanged.
REQ-020 SHALL give DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0, no exception.
REQ-021 SHALL write alu_res to HI on MTHI, LO on MTLO, at end of cycle when ex_valid & IDLE & !flush; busy stays 0.
REQ-022 SHALL ignore ex_valid/func while not IDLE (held instruction never re-accepted).
REQ-023 SHALL treat flush with priority over start, MTHI/MTLO and completion: busy=0 that cycle, state->IDLE, HI/LO unchanged, any in-flight result discarded.
REQ-024 SHALL accept a new start in the cycle after completion or flush.
REQ-025 SHALL drive busy = start | (state!=IDLE & not final cycle) & !flush, with no register on the path.

Reset
REQ-026 SHALL on reset set hi=0, lo=0, state=IDLE, counters=0; busy=0 while reset asserted.
REQ-027 SHALL let reset override flush, start and any in-progress MUL/DIV; no partial HI/LO write.

Structure
REQ-028 SHALL take MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO codes from the shared header/package; state encodings local.
REQ-029 SHALL place the restoring divider datapath (remainder/quotient shift registers, 6-bit iteration counter) in sub-module div_iter; multiply and sign-fix stay in muldiv_hilo.

Verification
REQ-030 SHALL cover: reset -> hi=0, lo=0, busy=0 next cycle.
REQ-031 SHALL cover: MULT A=0xFFFFFFFF B=2, M=2 -> busy 1 in cycles 0,1, 0 in cycle 2; hi=0xFFFFFFFF lo=0xFFFFFFFE; MULTU same -> hi=0x00000001 lo=0xFFFFFFFE.
REQ-032 SHALL cover: DIV A=0xFFFFFFF9 B=2 -> busy 32 cycles; lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU A=7 B=0 -> lo=0xFFFFFFFF hi=7.
REQ-033 SHALL cover: MTHI alu_res=0x12345678 then MFHI next cycle -> hi=0x12345678, busy never 1.
REQ-034 SHALL cover: flush in cycle 10 of DIV -> busy 0 same cycle, hi/lo unchanged, MULTU accepted next cycle completes normally.
REQ-035 SHALL cover: reset in cycle 5 of DIV -> hi=lo=0, IDLE, busy=0.

Source files
------------

// File: rtl/muldiv_hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// Holds the EX-stage function codes the unit decodes and small decode helpers.
package muldiv_hilo_pkg;

    // EX-stage function codes (R-type funct field).
    localparam logic [5:0] FuncMfhi  = 6'h10;
    localparam logic [5:0] FuncMthi  = 6'h11;
    localparam logic [5:0] FuncMflo  = 6'h12;
    localparam logic [5:0] FuncMtlo  = 6'h13;
    localparam logic [5:0] FuncMult  = 6'h18;
    localparam logic [5:0] FuncMultu = 6'h19;
    localparam logic [5:0] FuncDiv   = 6'h1A;
    localparam logic [5:0] FuncDivu  = 6'h1B;

    // True for the four codes that start a multi-cycle operation.
    function automatic logic is_muldiv(input logic [5:0] f);
        return (f == FuncMult) || (f == FuncMultu) || (f == FuncDiv) || (f == FuncDivu);
    endfunction

    function automatic logic is_div(input logic [5:0] f);
        return (f == FuncDiv) || (f == FuncDivu);
    endfunction

    // Signed variants of multiply/divide.
    function automatic logic is_signed_op(input logic [5:0] f);
        return (f == FuncMult) || (f == FuncDiv);
    endfunction

    // Absolute value for signed operands; pass-through otherwise.
    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_hilo_div_iter.sv
// Restoring divider datapath: one quotient bit per step over 32 steps.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   load                capture dividend/divisor magnitudes, clear remainder and counter
//   step                perform one iteration (registers advance)
//   clear               zero the iteration counter (cancelled operation)
//   dividend, divisor   unsigned magnitudes, sampled on load
//   quot_next, rem_next result of the iteration in progress this cycle
//   last                the iteration in progress is the 32nd one
module div_iter (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic        clear,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quot_next,
    output logic [31:0] rem_next,
    output logic        last
);

    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [5:0]  cnt_q;

    logic [32:0] shifted;
    logic [31:0] sub;
    logic        fits;

    // quo_q doubles as the dividend shift register: its MSB feeds the remainder
    // while the new quotient bit enters at the LSB.
    always_comb begin
        shifted   = {rem_q, quo_q[31]};
        fits      = (shifted >= {1'b0, dvs_q});
        // When fits, the difference is below the divisor and so fits 32 bits.
        sub       = shifted[31:0] - dvs_q;
        rem_next  = fits ? sub : shifted[31:0];
        quot_next = {quo_q[30:0], fits};
    end

    assign last = (cnt_q == 6'd31);

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (step) begin
            rem_q <= rem_next;
            quo_q <= quot_next;
            cnt_q <= cnt_q + 6'd1;
        end
    end

endmodule

// File: rtl/muldiv_hilo.sv
// HI/LO multiply/divide unit for a classic five-stage pipeline.
// MULT/MULTU finish after MUL_STAGES cycles, DIV/DIVU after 32 cycles;
// MTHI/MTLO write in a single cycle. busy is a combinational stall request.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   ex_valid     EX-stage instruction valid
//   func         EX function code
//   A, B         rs / rt operands
//   alu_res      EX ALU result (rs for MTHI/MTLO)
//   flush        cancels any EX-stage or in-flight work
//   busy         stall request
//   hi, lo       architectural HI/LO registers
module muldiv_hilo #(
    parameter int unsigned MUL_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [5:0]  func,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [31:0] alu_res,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    import muldiv_hilo_pkg::*;

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

    localparam logic [2:0] MulLast = 3'(MUL_STAGES);

    state_e      state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] a_q, b_q;
    logic        sgn_q;
    logic [2:0]  mcnt_q, mcnt_d;

    logic        idle;
    logic        start;
    logic        start_div;
    logic        sgn_in;
    logic        mul_final;
    logic        div_final;
    logic        div_last;
    logic [31:0] a_mag, b_mag;
    logic [31:0] quot_mag, rem_mag;
    logic [31:0] quot_fix, rem_fix;
    logic [63:0] a_ext, b_ext, prod;

    assign idle      = (state_q == StIdle);
    assign start     = ex_valid & idle & ~flush & ~reset & is_muldiv(func);
    assign start_div = start & is_div(func);
    assign sgn_in    = is_signed_op(func);
    assign a_mag     = magnitude(A, sgn_in);
    assign b_mag     = magnitude(B, sgn_in);

    assign mul_final = (state_q == StMul) & (mcnt_q == MulLast);
    assign div_final = (state_q == StDiv) & div_last;

    assign busy = ~reset & (start | ((state_q != StIdle) & ~mul_final & ~div_final & ~flush));

    div_iter u_div_iter (
        .clk      (clk),
        .reset    (reset),
        .load     (start_div),
        .step     ((state_q == StDiv) & ~flush),
        .clear    (flush),
        .dividend (a_mag),
        .divisor  (b_mag),
        .quot_next(quot_mag),
        .rem_next (rem_mag),
        .last     (div_last)
    );

    // Low 64 bits of the product of the extended operands equal the 32x32
    // product in either signedness.
    always_comb begin
        a_ext = sgn_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        b_ext = sgn_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        prod  = a_ext * b_ext;
    end

    // Quotient negated when operand signs differ; remainder follows the dividend.
    always_comb begin
        quot_fix = (sgn_q && (a_q[31] ^ b_q[31])) ? (32'd0 - quot_mag) : quot_mag;
        rem_fix  = (sgn_q && a_q[31]) ? (32'd0 - rem_mag) : rem_mag;
    end

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mcnt_d  = mcnt_q;
        if (flush) begin
            state_d = StIdle;
            mcnt_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = start_div ? StDiv : StMul;
                        mcnt_d  = start_div ? 3'd0 : 3'd1;
                    end else if (ex_valid && func == FuncMthi) begin
                        hi_d = alu_res;
                    end else if (ex_valid && func == FuncMtlo) begin
                        lo_d = alu_res;
                    end
                end
                StMul: begin
                    if (mul_final) begin
                        hi_d    = prod[63:32];
                        lo_d    = prod[31:0];
                        state_d = StIdle;
                        mcnt_d  = '0;
                    end else begin
                        mcnt_d = mcnt_q + 3'd1;
                    end
                end
                StDiv: begin
                    if (div_final) begin
                        hi_d    = rem_fix;
                        lo_d    = quot_fix;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            hi_q    <= '0;
            lo_q    <= '0;
            mcnt_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mcnt_q  <= mcnt_d;
            if (start) begin
                a_q   <= A;
                b_q   <= B;
                sgn_q <= sgn_in;
            end
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
module tb_muldiv_hilo;
    import muldiv_hilo_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [5:0]  func;
    logic [31:0] A, B, alu_res;
    logic        flush;
    logic        busy;
    logic [31:0] hi, lo;

    always #5 clk = ~clk;

    muldiv_hilo #(.MUL_STAGES(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .ex_valid(ex_valid),
        .func    (func),
        .A       (A),
        .B       (B),
        .alu_res (alu_res),
        .flush   (flush),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    typedef struct {
        string       name;
        logic [5:0]  func;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] alu;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          lat;
    } vec_t;

    vec_t        vecs[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_hi, m_lo;
    logic [31:0] h0, l0;

    function automatic vec_t mk(input string n, input logic [5:0] f, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] alu,
                                input logic [31:0] eh, input logic [31:0] el, input int lat);
        vec_t v;
        v.name = n; v.func = f; v.a = a; v.b = b; v.alu = alu;
        v.exp_hi = eh; v.exp_lo = el; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge (start of the next cycle).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction, held while busy as a stalled pipeline would, and
    // measure the busy run. Starts and ends just after a rising edge.
    task automatic run_vec(input vec_t v, output logic [31:0] hi_at0, output logic [31:0] lo_at0);
        int c;
        c = 0;
        ex_valid = 1'b1; func = v.func; A = v.a; B = v.b; alu_res = v.alu;
        @(negedge clk);
        hi_at0 = hi; lo_at0 = lo;
        while (busy && c < 40) begin
            c++;
            tick();
            @(negedge clk);
        end
        chk({v.name, " latency"}, 32'(c), 32'(v.lat));
        tick();
        ex_valid = 1'b0; func = 6'h00;
        @(negedge clk);
        chk({v.name, " hi"}, hi, v.exp_hi);
        chk({v.name, " lo"}, lo, v.exp_lo);
        m_hi = v.exp_hi; m_lo = v.exp_lo;
        tick();
    endtask

    initial begin
        vecs.push_back(mk("mult_neg1x2", FuncMult, 32'hFFFFFFFF, 32'd2, 32'h0,
                          32'hFFFFFFFF, 32'hFFFFFFFE, 2));
        vecs.push_back(mk("multu_ffx2", FuncMultu, 32'hFFFFFFFF, 32'd2, 32'h0,
                          32'h00000001, 32'hFFFFFFFE, 2));
        vecs.push_back(mk("div_m7_2", FuncDiv, 32'hFFFFFFF9, 32'd2, 32'h0,
                          32'hFFFFFFFF, 32'hFFFFFFFD, 32));
        vecs.push_back(mk("divu_7_0", FuncDivu, 32'd7, 32'd0, 32'h0,
                          32'd7, 32'hFFFFFFFF, 32));
        vecs.push_back(mk("div_min_m1", FuncDiv, 32'h80000000, 32'hFFFFFFFF, 32'h0,
                          32'h0, 32'h80000000, 32));
        vecs.push_back(mk("mthi", FuncMthi, 32'h0, 32'h0, 32'h12345678,
                          32'h12345678, 32'h80000000, 0));
        vecs.push_back(mk("mfhi", FuncMfhi, 32'h0, 32'h0, 32'hDEADBEEF,
                          32'h12345678, 32'h80000000, 0));
        vecs.push_back(mk("mtlo", FuncMtlo, 32'h0, 32'h0, 32'hCAFEF00D,
                          32'h12345678, 32'hCAFEF00D, 0));
        vecs.push_back(mk("mflo", FuncMflo, 32'h0, 32'h0, 32'h55555555,
                          32'h12345678, 32'hCAFEF00D, 0));
        vecs.push_back(mk("divu_100_7", FuncDivu, 32'd100, 32'd7, 32'h0,
                          32'd2, 32'd14, 32));
        vecs.push_back(mk("mult_min_min", FuncMult, 32'h80000000, 32'h80000000, 32'h0,
                          32'h40000000, 32'h0, 2));
        vecs.push_back(mk("multu_max_max", FuncMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,
                          32'hFFFFFFFE, 32'h00000001, 2));
        vecs.push_back(mk("div_7_m2", FuncDiv, 32'd7, 32'hFFFFFFFE, 32'h0,
                          32'd1, 32'hFFFFFFFD, 32));
        vecs.push_back(mk("div_m8_0", FuncDiv, 32'hFFFFFFF8, 32'd0, 32'h0,
                          32'hFFFFFFF8, 32'h00000001, 32));
        vecs.push_back(mk("divu_hex", FuncDivu, 32'h12345678, 32'h00001000, 32'h0,
                          32'h00000678, 32'h00012345, 32));

        // Reset, with a MULT presented that must not raise busy.
        reset = 1'b1; flush = 1'b0; ex_valid = 1'b1; func = FuncMult;
        A = 32'd3; B = 32'd5; alu_res = 32'h0;
        tick();
        tick();
        @(negedge clk);
        chk("busy in reset", {31'd0, busy}, 32'd0);
        tick();
        reset = 1'b0; ex_valid = 1'b0; func = 6'h00;
        @(negedge clk);
        chk("reset hi", hi, 32'h0);
        chk("reset lo", lo, 32'h0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        tick();

        foreach (vecs[i]) run_vec(vecs[i], h0, l0);

        // Flush in the same cycle as a start: nothing accepted.
        ex_valid = 1'b1; func = FuncMult; A = 32'd3; B = 32'd5; flush = 1'b1;
        @(negedge clk);
        chk("flush+start busy", {31'd0, busy}, 32'd0);
        tick();
        ex_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("after flush+start busy", {31'd0, busy}, 32'd0);
        tick(); tick(); tick();
        @(negedge clk);
        chk("flush+start hi", hi, m_hi);
        chk("flush+start lo", lo, m_lo);
        tick();

        // Flush on the multiply completion cycle discards the result.
        ex_valid = 1'b1; func = FuncMult; A = 32'd3; B = 32'd5;
        tick(); tick();
        flush = 1'b1;
        @(negedge clk);
        chk("flush mul final busy", {31'd0, busy}, 32'd0);
        tick();
        flush = 1'b0; ex_valid = 1'b0;
        @(negedge clk);
        chk("flush mul hi", hi, m_hi);
        chk("flush mul lo", lo, m_lo);
        tick();

        // Flush in cycle 10 of a DIVU; MULTU accepted the very next cycle.
        ex_valid = 1'b1; func = FuncDivu; A = 32'd100; B = 32'd7;
        for (int i = 0; i < 10; i++) tick();
        @(negedge clk);
        chk("div cycle 10 pre-flush busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        #1;
        chk("div flush busy", {31'd0, busy}, 32'd0);
        tick();
        flush = 1'b0;
        run_vec(mk("multu_after_flush", FuncMultu, 32'h0000FFFF, 32'h00010001, 32'h0,
                   32'h0, 32'hFFFFFFFF, 2), h0, l0);
        chk("div flush hi kept", h0, 32'h00012345 == 32'h0 ? 32'h0 : 32'h00000678);
        chk("div flush lo kept", l0, 32'h00012345);

        // Reset in cycle 5 of a DIV.
        ex_valid = 1'b1; func = FuncDiv; A = 32'hFFFFFFF9; B = 32'd2;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1; ex_valid = 1'b0;
        @(negedge clk);
        chk("div reset busy", {31'd0, busy}, 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("div reset hi", hi, 32'h0);
        chk("div reset lo", lo, 32'h0);
        chk("div reset idle busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 40; i++) tick();
        @(negedge clk);
        chk("div reset no late hi", hi, 32'h0);
        chk("div reset no late lo", lo, 32'h0);
        tick();
        run_vec(mk("mult_after_reset", FuncMult, 32'd6, 32'd7, 32'h0,
                   32'h0, 32'd42, 2), h0, l0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
